branch_target_buffer: RTL and testbench

Parametrised, direct-mapped branch target buffer with per-entry saturating direction counters. It replaces the single-entry predictor held inside the fetch stage. Fetch looks up the current PC combinationally and gets a taken/target prediction in the same cycle. Execute writes resolved branch outcomes back; those updates become visible to lookups on the next cycle. Flush support and performance counters are included.

---
 rtl/branch_target_buffer_if.sv | 37 +++
 rtl/branch_target_buffer.sv | 110 +++++++++++
 tb/tb_branch_target_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/execute side bus of the branch target buffer: lookup request and
// prediction, resolved-branch update, flush and performance counters.
interface branch_target_buffer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             lookup_valid_in;
    logic [XLEN-1:0]  lookup_pc_in;
    logic             pred_taken_out;
    logic [XLEN-1:0]  pred_target_out;
    logic             update_valid_in;
    logic [XLEN-1:0]  update_pc_in;
    logic [XLEN-1:0]  update_target_in;
    logic             update_taken_in;
    logic             pred_wrong_in;
    logic             flush_in;
    logic [CNT_W-1:0] hit_count_out;
    logic [CNT_W-1:0] mispred_count_out;

    // Pipeline side: presents PCs and resolved branches, consumes predictions.
    modport master (
        output lookup_valid_in, lookup_pc_in,
        output update_valid_in, update_pc_in, update_target_in, update_taken_in,
        output pred_wrong_in, flush_in,
        input  pred_taken_out, pred_target_out,
        input  hit_count_out, mispred_count_out
    );

    // Predictor side.
    modport slave (
        input  lookup_valid_in, lookup_pc_in,
        input  update_valid_in, update_pc_in, update_target_in, update_taken_in,
        input  pred_wrong_in, flush_in,
        output pred_taken_out, pred_target_out,
        output hit_count_out, mispred_count_out
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is purely combinational; updates land on the clock edge
// and are seen by lookups from the following cycle (no bypass).
module branch_target_buffer #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 8,
    parameter int CTR_BITS = 2,
    parameter int MODE     = 1,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_target_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    // Entry storage. Kept in flops because the lookup must be combinational.
    logic                valid_reg  [ENTRIES];
    logic [TAG_W-1:0]    tag_reg    [ENTRIES];
    logic [XLEN-1:0]     target_reg [ENTRIES];
    logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];

    logic [CNT_W-1:0]    hit_cnt_reg;
    logic [CNT_W-1:0]    mispred_cnt_reg;

    // Address split: bits [1:0] are word offset and never participate.
    logic [IDX_W-1:0]    lk_idx, up_idx;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    logic [ENTRIES-1:0]  lk_match, up_match;
    logic                lk_hit, lk_dir, up_hit;
    logic [CTR_BITS-1:0] up_ctr, ctr_inc, ctr_dec;
    logic                unused_pc_bits;

    assign lk_idx = bus.lookup_pc_in[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc_in[XLEN-1:IDX_W+2];
    assign up_idx = bus.update_pc_in[IDX_W+1:2];
    assign up_tag = bus.update_pc_in[XLEN-1:IDX_W+2];
    assign unused_pc_bits = &{1'b0, bus.update_pc_in[1:0]};

    // Per-entry tag comparators for both the lookup and the update port.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign lk_match[gi] = valid_reg[gi] && (tag_reg[gi] == lk_tag);
            assign up_match[gi] = valid_reg[gi] && (tag_reg[gi] == up_tag);
        end
    endgenerate

    assign lk_hit = bus.lookup_valid_in & lk_match[lk_idx];
    // MODE 0 trusts any hit; MODE 1 follows the counter MSB.
    assign lk_dir = (MODE == 0) ? 1'b1 : ctr_reg[lk_idx][CTR_BITS-1];

    assign bus.pred_taken_out    = lk_hit & lk_dir;
    assign bus.pred_target_out   = bus.pred_taken_out ? target_reg[lk_idx]
                                                      : bus.lookup_pc_in + XLEN'(4);
    assign bus.hit_count_out     = hit_cnt_reg;
    assign bus.mispred_count_out = mispred_cnt_reg;

    // Saturating next counter values for the entry being updated.
    assign up_hit  = up_match[up_idx];
    assign up_ctr  = ctr_reg[up_idx];
    assign ctr_inc = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CTR_BITS'(1);
    assign ctr_dec = (up_ctr == '0)      ? up_ctr : up_ctr - CTR_BITS'(1);

    // Valid bits and direction counters: reset, then flush, then update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
                ctr_reg[i]   <= '0;
            end
        end else if (bus.flush_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
            end
        end else if (bus.update_valid_in) begin
            if (bus.update_taken_in) begin
                valid_reg[up_idx] <= 1'b1;
                ctr_reg[up_idx]   <= up_hit ? ctr_inc : CTR_WEAK;
            end else if (up_hit) begin
                ctr_reg[up_idx]   <= ctr_dec;
            end
        end
    end

    // Tag/target payload: written on every accepted taken update (a hit rewrites the same tag).
    always_ff @(posedge clk) begin
        if (reset_n && !bus.flush_in && bus.update_valid_in && bus.update_taken_in) begin
            tag_reg[up_idx]    <= up_tag;
            target_reg[up_idx] <= bus.update_target_in;
        end
    end

    // Performance counters: wrap naturally, untouched by flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_cnt_reg     <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (lk_hit) begin
                hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
            end
            if (bus.pred_wrong_in) begin
                mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: one bimodal instance (MODE=1) and
// one any-hit instance (MODE=0), sharing clock and reset.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_hits = 0;

    always #5 clk = ~clk;

    branch_target_buffer_if #(.XLEN(32), .CNT_W(32)) bus_a ();
    branch_target_buffer_if #(.XLEN(32), .CNT_W(32)) bus_b ();

    branch_target_buffer #(.XLEN(32), .ENTRIES(8), .CTR_BITS(2), .MODE(1), .CNT_W(32)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    branch_target_buffer #(.XLEN(32), .ENTRIES(8), .CTR_BITS(2), .MODE(0), .CNT_W(32)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive every input of instance A, then let combinational outputs settle.
    task automatic drv_a(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic [31:0] utgt, input logic ut,
                         input logic pw, input logic fl);
        bus_a.lookup_valid_in  = lv;
        bus_a.lookup_pc_in     = lpc;
        bus_a.update_valid_in  = uv;
        bus_a.update_pc_in     = upc;
        bus_a.update_target_in = utgt;
        bus_a.update_taken_in  = ut;
        bus_a.pred_wrong_in    = pw;
        bus_a.flush_in         = fl;
        #1;
    endtask

    task automatic drv_b(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic [31:0] utgt, input logic ut);
        bus_b.lookup_valid_in  = lv;
        bus_b.lookup_pc_in     = lpc;
        bus_b.update_valid_in  = uv;
        bus_b.update_pc_in     = upc;
        bus_b.update_target_in = utgt;
        bus_b.update_taken_in  = ut;
        bus_b.pred_wrong_in    = 1'b0;
        bus_b.flush_in         = 1'b0;
        #1;
    endtask

    // Commit the current inputs on the next rising edge; resume 2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic look_a(input string tag, input logic [31:0] pc,
                          input logic taken, input logic [31:0] tgt);
        drv_a(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_taken"}, 64'(bus_a.pred_taken_out), 64'(taken));
        chk({tag, "_target"}, 64'(bus_a.pred_target_out), 64'(tgt));
        $display("lookup %s pc=0x%08h taken=%0b target=0x%08h", tag, pc,
                 bus_a.pred_taken_out, bus_a.pred_target_out);
        cyc();
    endtask

    task automatic upd_a(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        drv_a(1'b0, 32'h0, 1'b1, pc, tgt, taken, 1'b0, 1'b0);
        $display("update pc=0x%08h target=0x%08h taken=%0b", pc, tgt, taken);
        cyc();
    endtask

    initial begin
        drv_a(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drv_b(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset: after the first reset edge the state is defined.
        cyc();
        drv_a(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_taken", 64'(bus_a.pred_taken_out), 64'd0);
        chk("rst_target", 64'(bus_a.pred_target_out), 64'h104);
        chk("rst_hits", 64'(bus_a.hit_count_out), 64'd0);
        chk("rst_mispred", 64'(bus_a.mispred_count_out), 64'd0);
        cyc();
        reset_n = 1'b1;

        // Cold miss, then allocate.
        look_a("cold", 32'h100, 1'b0, 32'h104);
        chk("cold_hits", 64'(bus_a.hit_count_out), 64'd0);
        upd_a(32'h100, 32'h200, 1'b1);
        look_a("alloc", 32'h100, 1'b1, 32'h200);
        exp_hits = 1;
        chk("alloc_hits", 64'(bus_a.hit_count_out), 64'(exp_hits));

        // Hysteresis: 2 -> 1 (not taken, hit still counted).
        upd_a(32'h100, 32'h0, 1'b0);
        look_a("ctr1", 32'h100, 1'b0, 32'h104);
        exp_hits = 2;
        chk("ctr1_hits", 64'(bus_a.hit_count_out), 64'(exp_hits));
        // 1 -> 0 -> 0 (saturates low).
        upd_a(32'h100, 32'h0, 1'b0);
        upd_a(32'h100, 32'h0, 1'b0);
        look_a("ctr0", 32'h100, 1'b0, 32'h104);
        exp_hits = 3;
        // 0 -> 1: still not taken.
        upd_a(32'h100, 32'h200, 1'b1);
        look_a("ctr_up1", 32'h100, 1'b0, 32'h104);
        exp_hits = 4;
        // 1 -> 2: taken again.
        upd_a(32'h100, 32'h200, 1'b1);
        look_a("ctr_up2", 32'h100, 1'b1, 32'h200);
        exp_hits = 5;
        chk("hyst_hits", 64'(bus_a.hit_count_out), 64'(exp_hits));

        // Aliasing: 0x120 shares index 0 with tag 0x9, evicting 0x100.
        upd_a(32'h120, 32'h300, 1'b1);
        look_a("alias_old", 32'h100, 1'b0, 32'h104);
        look_a("alias_new", 32'h120, 1'b1, 32'h300);
        exp_hits = 6;
        chk("alias_hits", 64'(bus_a.hit_count_out), 64'(exp_hits));

        // Same-cycle collision from cold: no bypass.
        drv_a(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        drv_a(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
        chk("coll_same_taken", 64'(bus_a.pred_taken_out), 64'd0);
        chk("coll_same_target", 64'(bus_a.pred_target_out), 64'h104);
        $display("collision lookup+update pc=0x100 taken=%0b", bus_a.pred_taken_out);
        cyc();
        look_a("coll_next", 32'h100, 1'b1, 32'h200);
        exp_hits = 7;

        // Fill all eight indices.
        for (int i = 0; i < 8; i++) begin
            upd_a(32'h100 + 32'(4 * i), 32'h400 + 32'(4 * i), 1'b1);
        end
        look_a("fill7", 32'h11C, 1'b1, 32'h41C);
        exp_hits = 8;

        // Flush together with an update: flush wins everywhere.
        drv_a(1'b0, 32'h0, 1'b1, 32'h104, 32'h999, 1'b1, 1'b0, 1'b1);
        $display("flush with update pc=0x104");
        cyc();
        for (int i = 0; i < 8; i++) begin
            look_a($sformatf("flushed%0d", i), 32'h100 + 32'(4 * i), 1'b0, 32'h104 + 32'(4 * i));
        end
        chk("flush_hits", 64'(bus_a.hit_count_out), 64'(exp_hits));

        // Mispredict counter, with a flush in the middle that must not clear it.
        chk("mispred0", 64'(bus_a.mispred_count_out), 64'd0);
        drv_a(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc();
        drv_a(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc();
        drv_a(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc();
        drv_a(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mispred3", 64'(bus_a.mispred_count_out), 64'd3);
        $display("mispredict pulses=3 count=%0d", bus_a.mispred_count_out);

        // Reset mid-stream: drops the in-flight update, clears counters and entries.
        upd_a(32'h108, 32'h500, 1'b1);
        reset_n = 1'b0;
        drv_a(1'b0, 32'h0, 1'b1, 32'h10C, 32'h600, 1'b1, 1'b1, 1'b0);
        cyc();
        reset_n = 1'b1;
        drv_a(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst2_hits", 64'(bus_a.hit_count_out), 64'd0);
        chk("rst2_mispred", 64'(bus_a.mispred_count_out), 64'd0);
        look_a("rst2_old", 32'h108, 1'b0, 32'h10C);
        look_a("rst2_drop", 32'h10C, 1'b0, 32'h110);
        chk("rst2_hits_after", 64'(bus_a.hit_count_out), 64'd0);

        // PC+4 wraps modulo 2^32.
        look_a("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Idle lookup port never predicts taken, even on a stored entry.
        upd_a(32'h100, 32'h200, 1'b1);
        drv_a(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("novalid_taken", 64'(bus_a.pred_taken_out), 64'd0);
        chk("novalid_target", 64'(bus_a.pred_target_out), 64'h104);
        cyc();

        // MODE=0: any hit predicts taken regardless of the counter.
        drv_b(1'b0, 32'h0, 1'b1, 32'h100, 32'h200, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drv_b(1'b0, 32'h0, 1'b1, 32'h100, 32'h0, 1'b0);
            cyc();
        end
        // Not-taken miss on the same index changes nothing.
        drv_b(1'b0, 32'h0, 1'b1, 32'h140, 32'h0, 1'b0);
        cyc();
        drv_b(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mode0_taken", 64'(bus_b.pred_taken_out), 64'd1);
        chk("mode0_target", 64'(bus_b.pred_target_out), 64'h200);
        $display("mode0 lookup pc=0x100 taken=%0b target=0x%08h",
                 bus_b.pred_taken_out, bus_b.pred_target_out);
        cyc();
        drv_b(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mode0_hits", 64'(bus_b.hit_count_out), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
